reg_file_param: RTL and testbench

Parametrised multi-read-port register file, the successor to the fixed 16 x 16-bit file in the CPU datapath. It adds configurable width, depth and read-port count, write-to-read bypass, and an optional hardwired zero register. It also adds a sequential clear engine that zeroes the array one entry per cycle on request. It feeds the ALU operand buses and exposes a flat debug dump of all registers.

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_file_rd_port.sv | 28 ++
 rtl/reg_file_param.sv | 71 +++++++
 tb/tb_reg_file_param.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types, defaults and address-width helper for the register file
package reg_file_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_NUM_RD = 2;
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one combinational read port with range check, zero register and write bypass
module reg_file_rd_port #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    wr_ok,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [DEPTH*DATA_W-1:0] mem,
  output logic [DATA_W-1:0]       data
);
  logic [DATA_W-1:0] entry;
  logic in_range;
  assign in_range = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
  // select the stored entry addressed by this port
  always_comb begin
    entry = '0;
    for (int i = 0; i < DEPTH; i++)
      if (addr == ADDR_W'(i)) entry = mem[i*DATA_W +: DATA_W];
  end
  assign data = !in_range ? '0 :
                (ZERO_REG != 0 && addr == '0) ? '0 :
                (BYPASS != 0 && wr_ok && wr_addr == addr) ? wr_data : entry;
endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised multi-read-port register file with bypass and sequential clear engine
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = addr_width(DEPTH),
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_start,
  output logic                     busy,
  output logic                     wr_drop,
  output logic [DEPTH*DATA_W-1:0]  dump
);
  logic [DEPTH*DATA_W-1:0] mem;
  state_t state, state_d;
  logic [ADDR_W-1:0] clr_idx, clr_idx_d;
  logic wr_in_range, wr_ok;
  assign wr_in_range = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH);
  assign wr_ok = wr_en && state == IDLE && wr_in_range && !(ZERO_REG != 0 && wr_addr == '0);
  assign dump = mem;
  // next state and clear index: stay in CLEAR until the last entry has been zeroed
  always_comb begin
    state_d = (state == IDLE) ? (clr_start ? CLEAR : IDLE) :
              (clr_idx == ADDR_W'(DEPTH-1)) ? IDLE : CLEAR;
    clr_idx_d = (state == CLEAR && state_d == CLEAR) ? clr_idx + ADDR_W'(1) : '0;
  end
  // state, clear counter, busy and reject flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      clr_idx <= '0;
      busy <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state <= state_d;
      clr_idx <= clr_idx_d;
      busy <= state_d == CLEAR;
      wr_drop <= wr_en && (state == CLEAR || !wr_in_range);
    end
  end
  // array update: clear engine zeroes one entry per cycle, otherwise accepted writes commit
  always_ff @(posedge clk) begin
    if (rst) mem <= '0;
    else
      for (int i = 0; i < DEPTH; i++)
        if (state == CLEAR && clr_idx == ADDR_W'(i)) mem[i*DATA_W +: DATA_W] <= '0;
        else if (wr_ok && wr_addr == ADDR_W'(i)) mem[i*DATA_W +: DATA_W] <= wr_data;
  end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr(rd_addr[g*ADDR_W +: ADDR_W]),
      .wr_ok(wr_ok),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .mem(mem),
      .data(rd_data[g*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed checks of four register file configurations sharing one stimulus
module tb_reg_file_param;
  logic clk = 0, rst = 1, wr_en = 0, clr_start = 0;
  logic [3:0] wr_addr = 0;
  logic [15:0] wr_data = 0;
  logic [7:0] rd_addr = 0;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic [3:0] busy, drop;
  logic [255:0] dump0, dump1, dump3;
  logic [191:0] dump2;
  int checks = 0, failures = 0, k;

  always #5 clk = ~clk;

  reg_file_param #(.BYPASS(1), .ZERO_REG(0)) d0 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd0), .clr_start(clr_start), .busy(busy[0]),
    .wr_drop(drop[0]), .dump(dump0));
  reg_file_param #(.BYPASS(0), .ZERO_REG(0)) d1 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd1), .clr_start(clr_start), .busy(busy[1]),
    .wr_drop(drop[1]), .dump(dump1));
  reg_file_param #(.DEPTH(12), .BYPASS(1), .ZERO_REG(0)) d2 (.clk(clk), .rst(rst), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd2), .clr_start(clr_start),
    .busy(busy[2]), .wr_drop(drop[2]), .dump(dump2));
  reg_file_param #(.BYPASS(1), .ZERO_REG(1)) d3 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd3), .clr_start(clr_start), .busy(busy[3]),
    .wr_drop(drop[3]), .dump(dump3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    step();
    step();
    rst = 0;
    rd(4'd0, 4'd9);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_drop", 32'(drop), 32'h0);
    check("rst_dump", 32'(|{dump0, dump1, dump2, dump3}), 32'h0);
    check("rst_rd", rd0, 32'h0);
    // plain write then read on both ports
    wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF;
    step();
    wr_en = 0;
    rd(4'd5, 4'd5);
    check("wr_r5", rd0, 32'hBEEF_BEEF);
    check("dump_r5", 32'(dump0[5*16 +: 16]), 32'hBEEF);
    // same-cycle bypass
    wr_en = 1; wr_addr = 3; wr_data = 16'h1234;
    rd(4'd3, 4'd5);
    check("byp_on", rd0, 32'hBEEF_1234);
    check("byp_off", rd1, 32'hBEEF_0000);
    check("byp_dump", 32'(dump0[3*16 +: 16]), 32'h0);
    step();
    wr_en = 0;
    #1;
    check("nobyp_late", rd1, 32'hBEEF_1234);
    // out-of-range write on the 12-deep file
    wr_en = 1; wr_addr = 13; wr_data = 16'h5555;
    rd(4'd13, 4'd5);
    check("oor_rd", rd2, 32'hBEEF_0000);
    check("oor_byp16", rd0, 32'hBEEF_5555);
    step();
    wr_en = 0;
    #1;
    check("oor_drop", 32'(drop), 32'h4);
    check("oor_rd_after", rd2, 32'hBEEF_0000);
    step();
    check("oor_drop_pulse", 32'(drop), 32'h0);
    // hardwired zero register
    wr_en = 1; wr_addr = 0; wr_data = 16'hAAAA;
    rd(4'd0, 4'd5);
    check("zr_byp", rd3, 32'hBEEF_0000);
    step();
    wr_en = 0;
    #1;
    check("zr_rd", rd3, 32'hBEEF_0000);
    check("zr_drop", 32'(drop), 32'h0);
    check("zr_dump", 32'(dump3[15:0]), 32'h0);
    check("zr_other", rd0, 32'hBEEF_AAAA);
    // fill then sequential clear
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = 16'h00FF;
      step();
    end
    wr_en = 0;
    clr_start = 1;
    step();
    clr_start = 0;
    rd(4'd0, 4'd15);
    check("clr_busy0", 32'(busy), 32'hF);
    check("clr_start_state", rd0, 32'h00FF_00FF);
    wr_en = 1; wr_addr = 2; wr_data = 16'h7777;
    step();
    wr_en = 0;
    rd(4'd2, 4'd15);
    check("clr_drop", 32'(drop[0]), 32'h1);
    check("clr_r2_kept", rd0, 32'h00FF_00FF);
    rd(4'd0, 4'd15);
    check("clr_r0", rd0, 32'h00FF_0000);
    k = 1;
    while (busy[0] === 1'b1 && k < 40) begin
      if (k == 2) check("clr_drop_pulse", 32'(drop[0]), 32'h0);
      if (k == 15) check("clr_r15_last", rd0, 32'h00FF_0000);
      step();
      k++;
    end
    check("clr_len", k, 16);
    check("clr_dump", 32'(|{dump0, dump1, dump2, dump3}), 32'h0);
    check("clr_busy_done", 32'(busy), 32'h0);
    // reset in the middle of a clear
    wr_en = 1; wr_addr = 9; wr_data = 16'h1111;
    step();
    wr_en = 0;
    clr_start = 1;
    step();
    clr_start = 0;
    repeat (7) step();
    check("mid_busy", 32'(busy[0]), 32'h1);
    rst = 1;
    step();
    rst = 0;
    rd(4'd9, 4'd5);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_r9", rd0, 32'h0);
    check("mid_rst_dump", 32'(|dump0), 32'h0);
    wr_en = 1; wr_addr = 4; wr_data = 16'h4242;
    step();
    wr_en = 0;
    rd(4'd4, 4'd5);
    check("mid_rst_idle_wr", rd0, 32'h0000_4242);
    clr_start = 1;
    step();
    clr_start = 0;
    #1;
    k = 0;
    while (busy[0] === 1'b1 && k < 40) begin
      step();
      k++;
    end
    check("reclr_len", k, 16);
    check("reclr_dump", 32'(|dump0), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
